// File: rtl/argon_alu_pkg.sv
// Shared types for the sequenced Argon ALU: opcodes, flag bit positions,
// controller states and serial-unit modes.
package argon_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADC  = 4'h1,
    OP_SBC  = 4'h2,
    OP_CMP  = 4'h3,
    OP_INC  = 4'h4,
    OP_DEC  = 4'h5,
    OP_NAND = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_NOR  = 4'h9,
    OP_XOR  = 4'hA,
    OP_LSH  = 4'hB,
    OP_RSH  = 4'hC,
    OP_ASR  = 4'hD,
    OP_MUL  = 4'hE,
    OP_RSV  = 4'hF
  } opcode_e;

  localparam int FLG_C   = 0;
  localparam int FLG_Z   = 1;
  localparam int FLG_EQ  = 2;
  localparam int FLG_GT  = 3;
  localparam int FLG_LT  = 4;
  localparam int FLG_BR  = 5;
  localparam int FLG_OV  = 6;
  localparam int FLG_RSV = 7;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_e;

  typedef enum logic [1:0] {SU_LSH, SU_RSH, SU_ASR, SU_MUL} su_mode_e;

  function automatic su_mode_e su_mode(input opcode_e op);
    case (op)
      OP_LSH:  return SU_LSH;
      OP_RSH:  return SU_RSH;
      OP_ASR:  return SU_ASR;
      default: return SU_MUL;
    endcase
  endfunction

endpackage

// File: rtl/argon_alu_seq_if.sv
// CPU internal bus view of the Argon ALU: write data, latch/start strobes,
// read selects, and the read/busy/done returns.
interface argon_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_bus;
  logic [WIDTH-1:0] o_bus;
  logic             o_bus_valid;
  logic             i_latchA;
  logic             i_latchB;
  logic             i_latchF;
  logic             i_latchOp;
  logic             i_start;
  logic             i_outputY;
  logic             i_outputF;
  logic             i_outputH;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_bus, i_latchA, i_latchB, i_latchF, i_latchOp, i_start,
           i_outputY, i_outputF, i_outputH,
    input  o_bus, o_bus_valid, o_busy, o_done
  );

  modport slave (
    input  i_bus, i_latchA, i_latchB, i_latchF, i_latchOp, i_start,
           i_outputY, i_outputF, i_outputH,
    output o_bus, o_bus_valid, o_busy, o_done
  );
endinterface

// File: rtl/argon_alu_serial_unit.sv
// Serial datapath: one shift (or one shift-add multiply step) per clock,
// paced by a down-counter; last_o flags the edge that produces the result.
module argon_alu_serial_unit
  import argon_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       start_i,
  input  su_mode_e                   mode_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [$clog2(WIDTH)-1:0]   k_i,
  output logic                       last_o,
  output logic [WIDTH-1:0]           y_o,
  output logic [WIDTH-1:0]           h_o,
  output logic                       carry_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  su_mode_e         mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] work_q, acc_q, mcand_q;
  logic [WIDTH-1:0] work_d, acc_d, addend;
  logic [WIDTH:0]   sum;
  logic             cout_d;

  always_comb begin
    work_d = work_q;
    acc_d  = acc_q;
    cout_d = 1'b0;
    addend = '0;
    sum    = '0;
    unique case (mode_q)
      SU_LSH: begin
        work_d = {work_q[WIDTH-2:0], 1'b0};
        cout_d = work_q[WIDTH-1];
      end
      SU_RSH: begin
        work_d = {1'b0, work_q[WIDTH-1:1]};
        cout_d = work_q[0];
      end
      SU_ASR: begin
        work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        cout_d = work_q[0];
      end
      default: begin
        // {acc, work} holds the partial product; the multiplier drains out of work's LSB
        addend = work_q[0] ? mcand_q : '0;
        sum    = {1'b0, acc_q} + {1'b0, addend};
        acc_d  = sum[WIDTH:1];
        work_d = {sum[0], work_q[WIDTH-1:1]};
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      mode_q  <= SU_LSH;
      cnt_q   <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else if (start_i) begin
      mode_q  <= mode_i;
      cnt_q   <= (mode_i == SU_MUL) ? CW'(WIDTH) : {1'b0, k_i};
      work_q  <= a_i;
      acc_q   <= '0;
      mcand_q <= b_i;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - CW'(1);
      work_q <= work_d;
      acc_q  <= acc_d;
    end
  end

  assign last_o  = (cnt_q == CW'(1));
  assign y_o     = work_d;
  assign h_o     = acc_d;
  assign carry_o = cout_d;

endmodule

// File: rtl/argon_alu_seq.sv
// Sequenced Argon ALU: bus-latched operands/flags/opcode, explicit start,
// busy/done handshake. Define ARGON_ALU_MUL_EN to build the multiply path.
//
// state | meaning
// IDLE  | accept latches/start; single-cycle ops commit here
// SHIFT | serial shift in progress, k edges
// MUL   | shift-add multiply in progress, WIDTH edges
module argon_alu_seq
  import argon_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 8
) (
  input logic            i_Clk,
  input logic            i_Reset,
  argon_alu_seq_if.slave bus
);
  localparam int KW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e            state_q;
  opcode_e           op_q;
  logic [WIDTH-1:0]  a_q, b_q, y_q, y_d, h_rd, opnd;
  logic [FLAG_W-1:0] flags_q, flags_d, flags_wr;
  logic [WIDTH:0]    sum;
  logic [KW-1:0]     k;
  logic              done_q, cin, is_shift, is_mul, su_start;
  logic              su_last, su_carry;
  logic [WIDTH-1:0]  su_y, su_h;

  assign k        = b_q[KW-1:0];
  assign is_shift = op_q inside {OP_LSH, OP_RSH, OP_ASR};
  assign su_start = (state_q == IDLE) && bus.i_start &&
                    !(bus.i_latchA || bus.i_latchB || bus.i_latchF || bus.i_latchOp) &&
                    ((is_shift && k != '0) || is_mul);

  always_comb begin
    flags_wr          = FLAG_W'(bus.i_bus);
    flags_wr[FLG_RSV] = 1'b0;
  end

  // Single-cycle result; reserved opcodes leave Y and flags as they are.
  always_comb begin
    y_d     = y_q;
    flags_d = flags_q;
    opnd    = b_q;
    cin     = 1'b0;
    sum     = '0;
    unique case (op_q)
      OP_ADD, OP_ADC, OP_INC: begin
        if (op_q == OP_INC) opnd = WIDTH'(1);
        if (op_q == OP_ADC) cin = flags_q[FLG_C];
        sum              = {1'b0, a_q} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
        y_d              = sum[MSB:0];
        flags_d[FLG_C]   = sum[WIDTH];
        flags_d[FLG_Z]   = (sum[MSB:0] == '0);
        flags_d[FLG_OV]  = (a_q[MSB] == opnd[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SBC, OP_DEC: begin
        if (op_q == OP_DEC) opnd = WIDTH'(1);
        if (op_q == OP_SBC) cin = flags_q[FLG_C];
        sum              = {1'b0, a_q} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin};
        y_d              = sum[MSB:0];
        flags_d[FLG_C]   = sum[WIDTH];
        flags_d[FLG_Z]   = (sum[MSB:0] == '0);
        flags_d[FLG_OV]  = (a_q[MSB] != opnd[MSB]) && (sum[MSB] != a_q[MSB]);
        if (op_q == OP_SBC) flags_d[FLG_BR] = sum[WIDTH];
      end
      OP_CMP: begin
        flags_d[FLG_Z]  = (a_q == b_q);
        flags_d[FLG_EQ] = (a_q == b_q);
        flags_d[FLG_GT] = (a_q > b_q);
        flags_d[FLG_LT] = (a_q < b_q);
      end
      OP_NAND, OP_AND, OP_OR, OP_NOR, OP_XOR: begin
        case (op_q)
          OP_NAND: y_d = ~(a_q & b_q);
          OP_AND:  y_d = a_q & b_q;
          OP_OR:   y_d = a_q | b_q;
          OP_NOR:  y_d = ~(a_q | b_q);
          default: y_d = a_q ^ b_q;
        endcase
        flags_d[FLG_Z]  = (y_d == '0);
        flags_d[FLG_OV] = 1'b0;
      end
      OP_LSH, OP_RSH, OP_ASR: begin
        y_d             = a_q;
        flags_d[FLG_C]  = 1'b0;
        flags_d[FLG_Z]  = (a_q == '0);
        flags_d[FLG_OV] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_latchA)       a_q     <= bus.i_bus;
          else if (bus.i_latchB)  b_q     <= bus.i_bus;
          else if (bus.i_latchF)  flags_q <= flags_wr;
          else if (bus.i_latchOp) op_q    <= opcode_e'(bus.i_bus[3:0]);
          else if (bus.i_start) begin
            if (su_start) begin
              state_q <= is_mul ? MUL : SHIFT;
            end else begin
              y_q     <= y_d;
              flags_q <= flags_d;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT, MUL: begin
          if (su_last) begin
            y_q            <= su_y;
            flags_q[FLG_C] <= (state_q == MUL) ? (su_h != '0) : su_carry;
            flags_q[FLG_Z] <= (su_y == '0) && ((state_q != MUL) || (su_h == '0));
            flags_q[FLG_OV] <= 1'b0;
            state_q        <= IDLE;
            done_q         <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARGON_ALU_MUL_EN
  logic [WIDTH-1:0] h_q;

  assign is_mul = (op_q == OP_MUL);
  assign h_rd   = h_q;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)                           h_q <= '0;
    else if (state_q == MUL && su_last)    h_q <= su_h;
  end
`else
  assign is_mul = 1'b0;
  assign h_rd   = '0;
`endif

  argon_alu_serial_unit #(.WIDTH(WIDTH)) u_serial (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .start_i (su_start),
    .mode_i  (su_mode(op_q)),
    .a_i     (a_q),
    .b_i     (b_q),
    .k_i     (k),
    .last_o  (su_last),
    .y_o     (su_y),
    .h_o     (su_h),
    .carry_o (su_carry)
  );

  always_comb begin
    bus.o_bus = '0;
    if (bus.i_outputY)      bus.o_bus = y_q;
    else if (bus.i_outputF) bus.o_bus = WIDTH'(flags_q);
    else if (bus.i_outputH) bus.o_bus = h_rd;
  end

  assign bus.o_bus_valid = bus.i_outputY | bus.i_outputF | bus.i_outputH;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_argon_alu_seq.sv
// Directed bench for argon_alu_seq (WIDTH=16); covers the MUL path when
// ARGON_ALU_MUL_EN is defined, the reserved-E behaviour otherwise.
module tb_argon_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  argon_alu_seq_if #(.WIDTH(16)) alu_if ();

  argon_alu_seq #(.WIDTH(16), .FLAG_W(8)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (alu_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // sel: 0=A 1=B 2=flags 3=opcode
  task automatic wr(input int sel, input logic [15:0] d);
    @(negedge clk);
    alu_if.i_bus     = d;
    alu_if.i_latchA  = (sel == 0);
    alu_if.i_latchB  = (sel == 1);
    alu_if.i_latchF  = (sel == 2);
    alu_if.i_latchOp = (sel == 3);
    @(negedge clk);
    alu_if.i_latchA  = 1'b0;
    alu_if.i_latchB  = 1'b0;
    alu_if.i_latchF  = 1'b0;
    alu_if.i_latchOp = 1'b0;
    alu_if.i_bus     = '0;
  endtask

  // sel: 0=Y 1=flags 2=H
  task automatic rd(input int sel, output logic [15:0] v);
    alu_if.i_outputY = (sel == 0);
    alu_if.i_outputF = (sel == 1);
    alu_if.i_outputH = (sel == 2);
    #1;
    v = alu_if.o_bus;
    alu_if.i_outputY = 1'b0;
    alu_if.i_outputF = 1'b0;
    alu_if.i_outputH = 1'b0;
    #1;
  endtask

  // n = clock edges after the start edge until o_done is seen
  task automatic run_op(input string tag, output int n);
    @(negedge clk);
    alu_if.i_start = 1'b1;
    @(negedge clk);
    alu_if.i_start = 1'b0;
    n = 0;
    while (!alu_if.o_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, alu_if.o_done, 1);
  endtask

  logic [3:0]  lop  [5] = '{4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
  logic [15:0] lexp [5] = '{16'hFFFA, 16'h0005, 16'h0007, 16'hFFF8, 16'h0002};

  initial begin
    logic [15:0] v;
    int n, busy_n, done_n;
    alu_if.i_bus = '0;
    alu_if.i_latchA = 0; alu_if.i_latchB = 0; alu_if.i_latchF = 0; alu_if.i_latchOp = 0;
    alu_if.i_start = 0;
    alu_if.i_outputY = 0; alu_if.i_outputF = 0; alu_if.i_outputH = 0;

    repeat (2) @(negedge clk);
    chk("rst_busy", alu_if.o_busy, 0);
    chk("rst_done", alu_if.o_done, 0);
    chk("rst_bus", alu_if.o_bus, 0);
    chk("rst_valid", alu_if.o_bus_valid, 0);
    rd(0, v); chk("rst_y", v, 16'h0000);
    rd(1, v); chk("rst_f", v, 16'h0000);
    rst = 1'b0;

    // ADD wraps to zero
    wr(0, 16'hFFFF); wr(1, 16'h0001); wr(3, 16'h0000);
    run_op("add", n);
    chk("add_lat", n, 0);
    rd(0, v); chk("add_y", v, 16'h0000);
    alu_if.i_outputF = 1'b1; #1;
    chk("add_valid", alu_if.o_bus_valid, 1);
    chk("add_f", alu_if.o_bus, 16'h0003);
    alu_if.i_outputF = 1'b0;
    @(negedge clk);
    chk("add_done_pulse", alu_if.o_done, 0);

    // SBC with carry in
    wr(2, 16'h0001); wr(0, 16'h0005); wr(1, 16'h0007); wr(3, 16'h0002);
    run_op("sbc", n);
    rd(0, v); chk("sbc_y", v, 16'hFFFD);
    rd(1, v); chk("sbc_f", v, 16'h0021);

    // CMP leaves Y alone
    wr(3, 16'h0003);
    run_op("cmp", n);
    rd(0, v); chk("cmp_y", v, 16'hFFFD);
    rd(1, v); chk("cmp_f", v, 16'h0031);

    for (int i = 0; i < 5; i++) begin
      wr(3, {12'h000, lop[i]});
      run_op("logic", n);
      chk("logic_lat", n, 0);
      rd(0, v); chk("logic_y", v, lexp[i]);
    end

    // DEC across the signed boundary
    wr(0, 16'h8000); wr(3, 16'h0005);
    run_op("dec", n);
    rd(0, v); chk("dec_y", v, 16'h7FFF);
    rd(1, v); chk("dec_f", v, 16'h0070);

    // ASR by 4, with a latch+start attempt while busy
    wr(0, 16'h8001); wr(1, 16'h0004); wr(2, 16'h0001); wr(3, 16'h000D);
    @(negedge clk); alu_if.i_start = 1'b1;
    @(negedge clk); alu_if.i_start = 1'b0;
    n = 0; busy_n = 0;
    while (!alu_if.o_done && n < 40) begin
      if (alu_if.o_busy) busy_n++;
      if (n == 0) begin
        alu_if.i_bus = 16'h1234; alu_if.i_latchA = 1'b1; alu_if.i_start = 1'b1;
      end else if (n == 1) begin
        alu_if.i_bus = '0; alu_if.i_latchA = 1'b0; alu_if.i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("asr_done", alu_if.o_done, 1);
    chk("asr_lat", n, 4);
    chk("asr_busy_cycles", busy_n, 4);
    chk("asr_busy_end", alu_if.o_busy, 0);
    rd(0, v); chk("asr_y", v, 16'hF800);
    rd(1, v); chk("asr_f", v, 16'h0000);
    @(negedge clk);
    chk("asr_done_pulse", alu_if.o_done, 0);

    // k=0: single cycle, Y=A (also shows A ignored the busy latch)
    wr(2, 16'h0001); wr(1, 16'h0000);
    run_op("asr0", n);
    chk("asr0_lat", n, 0);
    rd(0, v); chk("asr0_y", v, 16'h8001);
    rd(1, v); chk("asr0_f", v, 16'h0000);

    wr(1, 16'h0001); wr(3, 16'h000B);
    run_op("lsh", n);
    chk("lsh_lat", n, 1);
    rd(0, v); chk("lsh_y", v, 16'h0002);
    rd(1, v); chk("lsh_f", v, 16'h0001);

    // k=15, upper B bits ignored
    wr(1, 16'h001F); wr(3, 16'h000C);
    run_op("rsh", n);
    chk("rsh_lat", n, 15);
    rd(0, v); chk("rsh_y", v, 16'h0001);
    rd(1, v); chk("rsh_f", v, 16'h0000);

    // flag latch drops bits above FLAG_W and the reserved bit
    wr(2, 16'hFFD5);
    rd(1, v); chk("latf", v, 16'h0055);

    wr(3, 16'h000F);
    run_op("rsv", n);
    chk("rsv_lat", n, 0);
    rd(0, v); chk("rsv_y", v, 16'h0001);
    rd(1, v); chk("rsv_f", v, 16'h0055);

`ifdef ARGON_ALU_MUL_EN
    wr(0, 16'h1234); wr(1, 16'h0100); wr(3, 16'h000E);
    run_op("mul", n);
    chk("mul_lat", n, 16);
    rd(0, v); chk("mul_y", v, 16'h3400);
    rd(2, v); chk("mul_h", v, 16'h0012);
    rd(1, v); chk("mul_f", v, 16'h0015);
`else
    wr(3, 16'h000E);
    run_op("op_e", n);
    chk("op_e_lat", n, 0);
    rd(0, v); chk("op_e_y", v, 16'h0001);
    rd(1, v); chk("op_e_f", v, 16'h0055);
    alu_if.i_outputH = 1'b1; #1;
    chk("op_e_h_valid", alu_if.o_bus_valid, 1);
    chk("op_e_h", alu_if.o_bus, 16'h0000);
    alu_if.i_outputH = 1'b0;
`endif

    // reset during the 2nd SHIFT cycle
    wr(0, 16'h8001); wr(1, 16'h0004); wr(3, 16'h000D);
    @(negedge clk); alu_if.i_start = 1'b1;
    @(negedge clk); alu_if.i_start = 1'b0;
    chk("rstmid_busy_pre", alu_if.o_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", alu_if.o_busy, 0);
    chk("rstmid_done", alu_if.o_done, 0);
    rd(0, v); chk("rstmid_y", v, 16'h0000);
    rd(1, v); chk("rstmid_f", v, 16'h0000);
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (alu_if.o_done) done_n++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (alu_if.o_done) done_n++;
    end
    chk("rstmid_no_done", done_n, 0);
    chk("rstmid_busy_after", alu_if.o_busy, 0);

    // cleared opcode/operands: ADD 0+0
    run_op("post_rst", n);
    rd(0, v); chk("post_rst_y", v, 16'h0000);
    rd(1, v); chk("post_rst_f", v, 16'h0002);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
